// File: rtl/fb_ram.sv
// Single-clock framebuffer RAM: byte-enabled write port, registered read port,
// selectable read-during-write behaviour and a one-word-per-cycle clear engine.
module fb_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2**ADDR_WIDTH,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   read_addr,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    read_valid,
   input  logic                    clear_req,
   input  logic [DATA_WIDTH-1:0]   clear_value,
   output logic                    clear_busy,
   output logic                    clear_done
);
   localparam int NB = DATA_WIDTH / 8;
   // One extra bit so a full-size memory ends the clear without wrapping.
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST_L  = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     clr_addr_q, clr_addr_d;
   logic [DATA_WIDTH-1:0]   clr_value_q, clr_value_d;
   logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
   logic                    read_valid_q, read_valid_d;
   logic                    clear_busy_q, clear_done_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    wr_en_s;
   logic [ADDR_WIDTH-1:0]   wr_idx_s;
   logic [DATA_WIDTH-1:0]   wr_word_s;
   logic [NB-1:0]           wr_mask_s;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [NB-1:0]         mask
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < NB; i++) begin
         if (mask[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   // Clear FSM next state and fill address/value.
   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      clr_value_d = clr_value_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d     = ST_CLEAR;
               clr_addr_d  = {(ADDR_WIDTH+1){1'b0}};
               clr_value_d = clear_value;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + ONE_L;
            if (clr_addr_q == LAST_L) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Write-port arbitration: the clear engine owns the port while clearing.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = wr_addr;
      wr_word_s = wr_data;
      wr_mask_s = wr_be;
      if (state_q == ST_CLEAR) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = clr_addr_q[ADDR_WIDTH-1:0];
         wr_word_s = clr_value_q;
         wr_mask_s = {NB{1'b1}};
      end else if (we && ({1'b0, wr_addr} < DEPTH_L)) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Read next state, including same-address bypass of the active write.
   always_comb begin
      read_data_d  = read_data_q;
      read_valid_d = 1'b0;
      if (re) begin
         read_valid_d = 1'b1;
         if ({1'b0, read_addr} < DEPTH_L) begin
            if (BYPASS && wr_en_s && (wr_idx_s == read_addr)) begin
               read_data_d = merge_bytes(mem_q[read_addr], wr_word_s, wr_mask_s);
            end else begin
               read_data_d = mem_q[read_addr];
            end
         end else begin
            read_data_d = {DATA_WIDTH{1'b0}};
         end
      end else begin
         read_valid_d = 1'b0;
      end
   end

   // Storage array; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_idx_s] <= merge_bytes(mem_q[wr_idx_s], wr_word_s, wr_mask_s);
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         clr_addr_q   <= {(ADDR_WIDTH+1){1'b0}};
         clr_value_q  <= {DATA_WIDTH{1'b0}};
         read_data_q  <= {DATA_WIDTH{1'b0}};
         read_valid_q <= 1'b0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         clr_value_q  <= clr_value_d;
         read_data_q  <= read_data_d;
         read_valid_q <= read_valid_d;
         clear_busy_q <= (state_d == ST_CLEAR);
         clear_done_q <= (state_d == ST_DONE);
      end
   end

   assign read_data  = read_data_q;
   assign read_valid = read_valid_q;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;
endmodule

// File: doc/fb_ram.md
# fb_ram

Parametrised single-clock framebuffer/scratch RAM for the graphics pipeline. It has one write port with byte enables and one registered read port with a valid flag. Read-during-write is selectable between bypass and old-data behaviour. A built-in clear engine fills the whole memory with a constant, one word per cycle. It replaces the plain async-read RAM in the VGA/rasteriser path, where a framebuffer clear and a pipelined pixel fetch are required.

## Interface
- ADDR_WIDTH, 8, address width in bits.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 2**ADDR_WIDTH, number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- BYPASS, 1, read-during-write to the same address: 1 returns new data, 0 returns old data.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- re  in  1  read request.
- read_addr  in  ADDR_WIDTH  read address.
- read_data  out  DATA_WIDTH  registered read data.
- read_valid  out  1  read_data updated this cycle.
- clear_req  in  1  start a clear (single-cycle or level; sampled only in IDLE).
- clear_value  in  DATA_WIDTH  fill word; latched when clear_req is accepted.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when a clear completes.

## Operation
- Storage is DEPTH × DATA_WIDTH. Memory contents are not affected by reset; after power-up they are undefined.
- Write: on a clk edge with we=1, not busy, and wr_addr < DEPTH, each byte with wr_be[i]=1 is written. Bytes with wr_be[i]=0 keep their value.
- Writes with wr_addr ≥ DEPTH are dropped. wr_be=0 is a no-op.
- Read: on a clk edge with re=1, read_data is loaded with mem[read_addr] and read_valid=1. When re=0, read_data holds its value and read_valid=0.
- A read with read_addr ≥ DEPTH loads 0 and still asserts read_valid.
- Read-during-write, same address, same edge:
  - BYPASS=1: read_data = merged word (new bytes where wr_be is set, old bytes elsewhere).
  - BYPASS=0: read_data = old word.
  - The same rule applies to clear-engine writes.
- Clear FSM states:
  - IDLE: clear_req=1 latches clear_value, sets clr_addr=0, and moves to CLEAR.
  - CLEAR: each cycle writes clear_value to clr_addr (all bytes) and increments clr_addr. When clr_addr = DEPTH-1 has been written, moves to DONE.
  - DONE: clear_done=1 for one cycle, then returns to IDLE.
- While clear_busy=1 (CLEAR state):
  - External writes are dropped silently.
  - Reads continue normally.
  - clear_req is ignored.
- In DONE, external writes are accepted again. clear_req is ignored until IDLE.
- Simultaneous we and accepted clear_req in IDLE: the external write is performed on that edge, then overwritten by the clear.
- Reset mid-clear: FSM returns to IDLE and the memory stays partially filled. No clear_done is issued.

## Timing
- Reset values: read_data=0, read_valid=0, clear_busy=0, clear_done=0, FSM=IDLE.
- Read latency is 1 cycle: re at edge N gives read_data/read_valid visible after edge N, for one cycle if re drops.
- Back-to-back reads give one result per cycle.
- Write latency: data written at edge N is returned by a read at edge N+1. At edge N itself the BYPASS rule applies.
- Clear timeline (clear_req accepted at edge N):
  - clear_busy=1 after edges N .. N+DEPTH-1.
  - Words 0..DEPTH-1 are written at edges N+1 .. N+DEPTH.
  - After edge N+DEPTH: clear_busy=0 and clear_done=1 for one cycle.
  - Total is DEPTH+1 cycles from request to done pulse.
- clr_addr uses ADDR_WIDTH+1 bits internally, so DEPTH = 2**ADDR_WIDTH terminates without wrap-around.

## Test plan
- Reset/basic: assert reset for 2 cycles; check all outputs are 0. Write 0xDEADBEEF to addr 5 with wr_be=4'hF; read addr 5 next cycle → read_data=0xDEADBEEF, read_valid=1 one cycle after re.
- Byte enable: addr 5 holds 0xDEADBEEF; write 0x11223344 with wr_be=4'b0101 → read returns 0xDE22BE44.
- Read-during-write: addr 7 holds 0xAAAAAAAA; write 0x55555555 to addr 7 with wr_be=4'b0011 while re=1 on addr 7 → BYPASS=1 gives 0xAAAA5555; BYPASS=0 gives 0xAAAAAAAA. Next read gives 0xAAAA5555 in both builds.
- Clear: DEPTH=256, clear_value=0x000000FF, pulse clear_req.
  - Check clear_busy for exactly 256 cycles and clear_done pulses once.
  - Issue we to addr 3 with 0x12345678 mid-clear → dropped.
  - Read all 256 addresses afterwards → all 0x000000FF.
- Reset mid-clear: start a clear with 0x0, assert reset after 10 busy cycles → busy=0, no clear_done. Addrs 0..9 read 0 and addr 200 keeps its prior value. A new clear_req is accepted afterwards.
- Out-of-range (DEPTH=200, ADDR_WIDTH=8): write to addr 250 → no effect on any word. Read addr 250 → read_data=0, read_valid=1. A clear takes 200 busy cycles.
